// File: rtl/mux_onehot_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_onehot_reg_if
//  Description : Bus bundle for the registered one-hot multiplexer.
//                Carries the packed data channels, the one-hot select, the
//                valid/clear qualifiers and every registered result.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    iData      NUM_INPUTS*DATA_WIDTH  packed channels, channel k at
//                                      iData[k*DATA_WIDTH +: DATA_WIDTH]
//    select     NUM_INPUTS             one-hot channel select
//    iValid     1                      qualifies select/iData
//    iClrErr    1                      synchronous clear of error state
//    oData      DATA_WIDTH             registered selected data
//    oValid     1                      oData refreshed by a legal select
//    oSelIdx    IDX_WIDTH              index of last legally selected channel
//    oErr       1                      one-cycle illegal-select pulse
//    oErrSticky 1                      sticky illegal-select flag
//    oErrCnt    ERR_CNT_WIDTH          saturating illegal-select count
//  Modports
//    master : drives the inputs, observes the results (source / testbench)
//    slave  : the multiplexer itself
// ============================================================================
interface mux_onehot_reg_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_INPUTS    = 4,
  parameter int ERR_CNT_WIDTH = 8
);

  localparam int IDX_WIDTH = $clog2(NUM_INPUTS);

  logic [NUM_INPUTS*DATA_WIDTH-1:0] iData;
  logic [NUM_INPUTS-1:0]            select;
  logic                             iValid;
  logic                             iClrErr;
  logic [DATA_WIDTH-1:0]            oData;
  logic                             oValid;
  logic [IDX_WIDTH-1:0]             oSelIdx;
  logic                             oErr;
  logic                             oErrSticky;
  logic [ERR_CNT_WIDTH-1:0]         oErrCnt;

  modport master (
    output iData,
    output select,
    output iValid,
    output iClrErr,
    input  oData,
    input  oValid,
    input  oSelIdx,
    input  oErr,
    input  oErrSticky,
    input  oErrCnt
  );

  modport slave (
    input  iData,
    input  select,
    input  iValid,
    input  iClrErr,
    output oData,
    output oValid,
    output oSelIdx,
    output oErr,
    output oErrSticky,
    output oErrCnt
  );

endinterface
`default_nettype wire

// File: rtl/mux_onehot_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_onehot_reg
//  Description : Registered one-hot N-input multiplexer with hold-last-value
//                on illegal selects, a one-cycle error pulse, a sticky error
//                flag and a saturating illegal-select counter. One cycle of
//                latency; the select decode is a parallel AND-OR.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH     width of each channel and of oData          (default 32)
//    NUM_INPUTS     channel count, legal range 2..16            (default 4)
//    ERR_CNT_WIDTH  width of the saturating error counter       (default 8)
//  Ports
//    clk    input   rising-edge system clock
//    rst_n  input   asynchronous active-low reset, clears every output
//    bus    slave   mux_onehot_reg_if bundle (data, select, qualifiers,
//                   registered results)
//  Build option
//    MUX_PRIO_EN    when defined, a multi-hot select resolves to its lowest
//                   set bit and is treated as legal; all-zero stays illegal.
// ============================================================================
module mux_onehot_reg #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_INPUTS    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mux_onehot_reg_if.slave  bus
);

  localparam int IDX_WIDTH = $clog2(NUM_INPUTS);

  // --------------------------------------------------------------------------
  // Channel unpacking
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] chan [NUM_INPUTS];

  generate
    for (genvar gk = 0; gk < NUM_INPUTS; gk++) begin : g_unpack
      assign chan[gk] = bus.iData[gk*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Select qualification
  //   grant : the one-hot vector actually fed to the AND-OR decode
  //   legal : grant holds exactly one set bit
  // --------------------------------------------------------------------------
  logic [NUM_INPUTS-1:0] grant;
  logic                  legal;

`ifdef MUX_PRIO_EN
  // x & -x isolates the lowest set bit, so any non-zero select collapses to
  // a single-bit grant without building a priority chain.
  assign grant = bus.select & (~bus.select + NUM_INPUTS'(1));
  assign legal = |bus.select;
`else
  // Clearing the lowest set bit leaves zero only for a power of two, which
  // together with the non-zero test means exactly one bit is set.
  assign grant = bus.select;
  assign legal = (|bus.select) &&
                 ((bus.select & (bus.select - NUM_INPUTS'(1))) == '0);
`endif

  // --------------------------------------------------------------------------
  // Parallel AND-OR decode of data and channel index
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] sel_data;
  logic [IDX_WIDTH-1:0]  sel_idx;

  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      sel_data = sel_data | (chan[k] & {DATA_WIDTH{grant[k]}});
      sel_idx  = sel_idx  | (IDX_WIDTH'(k) & {IDX_WIDTH{grant[k]}});
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]    data_d,   data_q;
  logic                     valid_d,  valid_q;
  logic [IDX_WIDTH-1:0]     idx_d,    idx_q;
  logic                     err_d,    err_q;
  logic                     sticky_d, sticky_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_d,    cnt_q;

  logic take;     // legal capture this edge
  logic illegal;  // qualified illegal select this edge
  logic cnt_full;

  assign take     = bus.iValid &  legal;
  assign illegal  = bus.iValid & ~legal;
  assign cnt_full = (cnt_q == {ERR_CNT_WIDTH{1'b1}});

  always_comb begin
    data_d   = data_q;
    idx_d    = idx_q;
    valid_d  = take;
    err_d    = illegal;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    if (take) begin
      data_d = sel_data;
      idx_d  = sel_idx;
    end

    // A concurrent clear and illegal select: the error wins, and the clear
    // still discards the old count so the new error counts as the first.
    if (illegal) begin
      sticky_d = 1'b1;
      if (bus.iClrErr) begin
        cnt_d = ERR_CNT_WIDTH'(1);
      end else if (!cnt_full) begin
        cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
      end
    end else if (bus.iClrErr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.oData      = data_q;
  assign bus.oValid     = valid_q;
  assign bus.oSelIdx    = idx_q;
  assign bus.oErr       = err_q;
  assign bus.oErrSticky = sticky_q;
  assign bus.oErrCnt    = cnt_q;

endmodule
`default_nettype wire
